// File: rtl/ffn_read_sequencer_pkg.sv
// Shared network constants, sequencer state encoding and a width helper
// for the FFN read sequencer slice.
package ffn_read_sequencer_pkg;

   localparam int NUM_KERNELS  = 2;
   localparam int FFN_IN_WIDTH = 22;
   localparam int FFN_DEPTH    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rdseq_state_t;

   // Bits needed to index 'value' items; never less than one bit.
   function automatic int rdseq_clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/ffn_read_sequencer_if.sv
// SRAM read bus plus the output word stream of the FFN read sequencer.
// Stream handshake: a word moves only in a cycle where out_valid and
// out_ready are both high; once out_valid rises it stays high, with
// out_data/out_port/out_last frozen, until that transfer happens.
interface ffn_read_sequencer_if #(
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = 22,
   parameter int ADDR_W    = 4,
   parameter int PORT_W    = 1
);
   logic [NUM_PORTS-1:0]        rd_en;
   logic [ADDR_W-1:0]           rd_addr;
   logic [DATA_W*NUM_PORTS-1:0] rd_data_vector;
   logic [DATA_W-1:0]           out_data;
   logic [PORT_W-1:0]           out_port;
   logic                        out_last;
   logic                        out_valid;
   logic                        out_ready;

   modport master (
      output rd_en, rd_addr, out_data, out_port, out_last, out_valid,
      input  rd_data_vector, out_ready
   );

   modport slave (
      input  rd_en, rd_addr, out_data, out_port, out_last, out_valid,
      output rd_data_vector, out_ready
   );
endinterface

// File: rtl/ffn_rdseq_fifo2.sv
// Two-entry register FIFO holding sampled SRAM words with their port and
// last tags. Entries are cleared on reset so the head reads as zero.
module ffn_rdseq_fifo2 #(
   parameter int DATA_W = 22,
   parameter int PORT_W = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic [PORT_W-1:0] push_port,
   input  logic              push_last,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic [PORT_W-1:0] head_port,
   output logic              head_last,
   output logic [1:0]        count
);
   logic [DATA_W-1:0] data_q [2];
   logic [PORT_W-1:0] port_q [2];
   logic              last_q [2];
   logic              wr_ptr;
   logic              rd_ptr;

   // Storage, pointers and occupancy; push and pop may share a cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         port_q[0] <= '0;
         port_q[1] <= '0;
         last_q[0] <= 1'b0;
         last_q[1] <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
      end else begin
         if (push) begin
            data_q[wr_ptr] <= push_data;
            port_q[wr_ptr] <= push_port;
            last_q[wr_ptr] <= push_last;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = data_q[rd_ptr];
   assign head_port = port_q[rd_ptr];
   assign head_last = last_q[rd_ptr];

endmodule

// File: rtl/ffn_read_sequencer.sv
// FFN read sequencer: on start, reads DEPTH words from each of NUM_PORTS
// kernel SRAMs over a shared address bus and streams them out.
// Build macro FFN_RDSEQ_INTERLEAVE_EN selects address-major order
// (all ports at address 0, then address 1, ...); default is port-major.
module ffn_read_sequencer
   import ffn_read_sequencer_pkg::*;
#(
   parameter int NUM_PORTS = NUM_KERNELS,
   parameter int DATA_W    = FFN_IN_WIDTH,
   parameter int DEPTH     = FFN_DEPTH,
   parameter int ADDR_W    = rdseq_clog2(DEPTH),
   parameter int PORT_W    = rdseq_clog2(NUM_PORTS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output rdseq_state_t        fsm_state,
   ffn_read_sequencer_if.master bus
);
   localparam logic [PORT_W-1:0] LAST_P = PORT_W'(NUM_PORTS - 1);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

   rdseq_state_t      state_q;
   rdseq_state_t      state_d;
   logic [PORT_W-1:0] port_cnt;
   logic [ADDR_W-1:0] addr_cnt;
   logic              inflight;
   logic [PORT_W-1:0] infl_port;
   logic              infl_last;
   logic [1:0]        fifo_count;
   logic [2:0]        occupancy;
   logic              pop;
   logic              issue;
   logic              credit_ok;
   logic              last_pair;
   logic [DATA_W-1:0] push_data;

   assign pop       = bus.out_valid & bus.out_ready;
   // Words buffered or in flight, less the one leaving this cycle, must
   // leave room for one more so the FIFO never overflows; counting the
   // pop keeps the stream at one word per cycle with ready held high.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
   assign credit_ok = (occupancy - {2'b00, pop}) < 3'd2;
   assign last_pair = (port_cnt == LAST_P) && (addr_cnt == LAST_A);
   assign issue     = (state_q == RUN) && credit_ok;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and done pulse.
   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         IDLE:  if (start) state_d = RUN;
         RUN:   if (issue && last_pair) state_d = DRAIN;
         DRAIN: begin
            if (pop && bus.out_last) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Port/address walk: cleared on an accepted start, stepped per read.
   always_ff @(posedge clock) begin
      if (reset || (state_q == IDLE && start)) begin
         port_cnt <= '0;
         addr_cnt <= '0;
      end else if (issue) begin
`ifdef FFN_RDSEQ_INTERLEAVE_EN
         if (port_cnt == LAST_P) begin
            port_cnt <= '0;
            addr_cnt <= addr_cnt + 1'b1;
         end else begin
            port_cnt <= port_cnt + 1'b1;
         end
`else
         if (addr_cnt == LAST_A) begin
            addr_cnt <= '0;
            port_cnt <= port_cnt + 1'b1;
         end else begin
            addr_cnt <= addr_cnt + 1'b1;
         end
`endif
      end
   end

   // Tags travel one cycle behind the read to meet the SRAM data.
   always_ff @(posedge clock) begin
      if (reset) begin
         inflight  <= 1'b0;
         infl_port <= '0;
         infl_last <= 1'b0;
      end else begin
         inflight  <= issue;
         infl_port <= port_cnt;
         infl_last <= last_pair;
      end
   end

   assign push_data = bus.rd_data_vector[infl_port*DATA_W +: DATA_W];

   ffn_rdseq_fifo2 #(
      .DATA_W (DATA_W),
      .PORT_W (PORT_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (inflight),
      .push_data (push_data),
      .push_port (infl_port),
      .push_last (infl_last),
      .pop       (pop),
      .head_data (bus.out_data),
      .head_port (bus.out_port),
      .head_last (bus.out_last),
      .count     (fifo_count)
   );

   assign bus.out_valid = (fifo_count != 2'd0);
   assign bus.rd_en     = issue ? (NUM_PORTS'(1) << port_cnt) : '0;
   assign bus.rd_addr   = issue ? addr_cnt : '0;
   assign busy          = (state_q != IDLE);
   assign fsm_state     = state_q;

endmodule

// File: tb/tb_ffn_read_sequencer.sv
// Directed bench for ffn_read_sequencer: 2 ports x 4 words (port p,
// address a holds 16*p+a) plus a 1 port x 1 word instance.
module tb_ffn_read_sequencer;
   import ffn_read_sequencer_pkg::*;

   localparam int NP = 2;
   localparam int DW = 22;
   localparam int DP = 4;
   localparam int AW = 2;
   localparam int PW = 1;

   // clock / reset
   logic clock = 1'b0;
   logic reset;
   logic start_a;
   logic start_b;
   always #5 clock = ~clock;

   logic         busy_a, done_a, busy_b, done_b;
   rdseq_state_t st_a, st_b;

   ffn_read_sequencer_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .PORT_W(PW)) bus_a ();
   ffn_read_sequencer_if #(.NUM_PORTS(1), .DATA_W(DW), .ADDR_W(1), .PORT_W(1)) bus_b ();

   ffn_read_sequencer #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .PORT_W(PW)) dut_a (
      .clock     (clock),
      .reset     (reset),
      .start     (start_a),
      .busy      (busy_a),
      .done      (done_a),
      .fsm_state (st_a),
      .bus       (bus_a)
   );

   ffn_read_sequencer #(.NUM_PORTS(1), .DATA_W(DW), .DEPTH(1), .ADDR_W(1), .PORT_W(1)) dut_b (
      .clock     (clock),
      .reset     (reset),
      .start     (start_b),
      .busy      (busy_b),
      .done      (done_b),
      .fsm_state (st_b),
      .bus       (bus_b)
   );

   // SRAM models with one cycle read latency
   logic [DW-1:0] sram_a [NP];
   logic [DW-1:0] sram_b;
   always @(posedge clock) begin
      for (int p = 0; p < NP; p++)
         if (bus_a.rd_en[p]) sram_a[p] <= DW'(16 * p) + DW'(bus_a.rd_addr);
      if (bus_b.rd_en[0]) sram_b <= 22'h12345;
   end
   assign bus_a.rd_data_vector = {sram_a[1], sram_a[0]};
   assign bus_b.rd_data_vector = sram_b;

   // reads issued but not yet accepted downstream
   int outstanding = 0;
   always @(posedge clock) begin
      if (reset) outstanding <= 0;
      else outstanding <= outstanding + ((bus_a.rd_en != '0) ? 1 : 0)
                          - ((bus_a.out_valid && bus_a.out_ready) ? 1 : 0);
   end

   // scoreboard: {last, port, data}
   int total = 0;
   int bad   = 0;
   logic [23:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic fill_exp();
      logic       l;
      logic [0:0] pp;
      logic [21:0] dd;
      exp_q.delete();
`ifdef FFN_RDSEQ_INTERLEAVE_EN
      for (int a = 0; a < DP; a++)
         for (int p = 0; p < NP; p++) begin
`else
      for (int p = 0; p < NP; p++)
         for (int a = 0; a < DP; a++) begin
`endif
            l  = (p == NP - 1) && (a == DP - 1);
            pp = 1'(p);
            dd = 22'(16 * p + a);
            exp_q.push_back({l, pp, dd});
         end
   endtask

   // mode 0: ready held high; 1: ready 1,0,0,1 repeating; 2: ready high, start re-pulsed
   task automatic run_a(input int mode);
      int          words;
      logic        stalled;
      logic        finished;
      logic [23:0] held, item, got_item;
      fill_exp();
      @(negedge clock);
      start_a = 1'b1;
      bus_a.out_ready = 1'b1;
      @(negedge clock);
      start_a  = 1'b0;
      words    = 0;
      stalled  = 1'b0;
      finished = 1'b0;
      held     = '0;
      for (int cyc = 1; cyc <= 60 && !finished; cyc++) begin
         if (cyc > 1) @(negedge clock);
         bus_a.out_ready = (mode == 1) ? ((cyc % 4) == 1 || (cyc % 4) == 0) : 1'b1;
         start_a = (mode == 2) && (cyc == 4 || cyc == 9);
         #1;
         check("busy", busy_a, 1);
         check("credit", outstanding <= 2, 1);
         check("rd_en_onehot", $countones(bus_a.rd_en) <= 1, 1);
         if (cyc == 1) begin
            check("first_rd_en", bus_a.rd_en, 2'b01);
            check("first_rd_addr", bus_a.rd_addr, 0);
         end
         if (mode != 1 && cyc < 3) check("early_valid", bus_a.out_valid, 0);
         if (mode != 1 && cyc >= 3) check("valid_gap", bus_a.out_valid, 1);
         got_item = {bus_a.out_last, bus_a.out_port, bus_a.out_data};
         if (stalled) begin
            check("stall_valid", bus_a.out_valid, 1);
            check("stall_hold", got_item, held);
         end
         stalled = bus_a.out_valid && !bus_a.out_ready;
         held    = got_item;
         if (bus_a.out_valid && bus_a.out_ready) begin
            words++;
            item = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hFFFFFF;
            check("word", got_item, item);
            check("done", done_a, item[23]);
            if (bus_a.out_last) finished = 1'b1;
         end else begin
            check("done_idle", done_a, 0);
         end
      end
      check("pass_end", finished, 1);
      check("word_count", words, NP * DP);
      @(negedge clock);
      start_a = 1'b0;
      #1;
      check("busy_after", busy_a, 0);
      check("valid_after", bus_a.out_valid, 0);
      check("state_after", st_a, IDLE);
   endtask

   initial begin
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      bus_a.out_ready = 1'b1;
      bus_b.out_ready = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_rd_en", bus_a.rd_en, 0);
      check("rst_rd_addr", bus_a.rd_addr, 0);
      check("rst_out_data", bus_a.out_data, 0);
      check("rst_out_valid", bus_a.out_valid, 0);
      check("rst_state", st_a, IDLE);
      reset = 1'b0;

      run_a(0);
      run_a(1);
      run_a(2);

      // reset during the third issued read
      @(negedge clock);
      start_a = 1'b1;
      bus_a.out_ready = 1'b1;
      @(negedge clock);
      start_a = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #1;
`ifdef FFN_RDSEQ_INTERLEAVE_EN
      check("third_rd_en", bus_a.rd_en, 2'b01);
      check("third_rd_addr", bus_a.rd_addr, 1);
`else
      check("third_rd_en", bus_a.rd_en, 2'b01);
      check("third_rd_addr", bus_a.rd_addr, 2);
`endif
      reset = 1'b1;
      @(negedge clock);
      #1;
      check("mid_busy", busy_a, 0);
      check("mid_done", done_a, 0);
      check("mid_rd_en", bus_a.rd_en, 0);
      check("mid_rd_addr", bus_a.rd_addr, 0);
      check("mid_out_data", bus_a.out_data, 0);
      check("mid_out_port", bus_a.out_port, 0);
      check("mid_out_last", bus_a.out_last, 0);
      check("mid_out_valid", bus_a.out_valid, 0);
      check("mid_state", st_a, IDLE);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         #1;
         check("post_rst_done", done_a, 0);
         check("post_rst_valid", bus_a.out_valid, 0);
      end
      run_a(0);

      // single port, single word
      @(negedge clock);
      start_b = 1'b1;
      @(negedge clock);
      start_b = 1'b0;
      #1;
      check("min_busy", busy_b, 1);
      check("min_valid1", bus_b.out_valid, 0);
      @(negedge clock);
      #1;
      check("min_valid2", bus_b.out_valid, 0);
      @(negedge clock);
      #1;
      check("min_valid3", bus_b.out_valid, 1);
      check("min_data", bus_b.out_data, 22'h12345);
      check("min_port", bus_b.out_port, 0);
      check("min_last", bus_b.out_last, 1);
      check("min_done", done_b, 1);
      @(negedge clock);
      #1;
      check("min_busy_after", busy_b, 0);
      check("min_done_after", done_b, 0);
      check("min_valid_after", bus_b.out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
